pmem_mp_latency: RTL and testbench
==================================

# pmem_mp_latency

Parametrised multi-port physical-memory model with byte-masked writes and a configurable, fixed per-request response latency. It is the successor to the two-port zero-wait magic memory used under the mp3 top level, and it serves as the backing store for instruction and data ports in the system testbench. Width, depth, port count and latency are generic. Cross-port read/write ordering at the same cycle is fully defined, so cache and arbiter miss paths can be exercised under realistic delay.

## Interface
Parameters:
- DATA_WIDTH, 16: data bits per word; must be a multiple of 8.
- ADDR_WIDTH, 16: byte-address width.
- DEPTH_WORDS, 4096: storage words; power of two.
- NUM_PORTS, 2: independent request ports, at least 1.
- LATENCY, 3: cycles from request acceptance to resp; at least 1.

Ports (per-port signals are unpacked arrays [NUM_PORTS]):
- clk  in  1  Clock; all state changes on its rising edge.
- rst  in  1  Synchronous, active-high reset.
- read  in  1  Read request; held high until resp.
- write  in  1  Write request; held high until resp.
- wmask  in  DATA_WIDTH/8  Byte enables for a write.
- address  in  ADDR_WIDTH  Byte address.
- wdata  in  DATA_WIDTH  Write data.
- resp  out  1  One-cycle completion pulse.
- rdata  out  DATA_WIDTH  Read data, valid while resp is high.

## Operation
- Word index = address[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)] mod DEPTH_WORDS. Low byte-offset bits are ignored. Upper bits wrap.
- Each port runs an independent FSM with states IDLE, BUSY and DONE.
- IDLE, with read or write high: accept the request. Latch op, word index, wdata and wmask. Load the counter with LATENCY-1 and go to BUSY.
- BUSY: decrement the counter. When the counter is 0, go to DONE on the next edge. On that same edge:
  - a read captures the memory word into rdata;
  - a write commits the enabled bytes.
- DONE: resp=1 for this single cycle, then return to IDLE. A request still high in the following IDLE cycle is treated as a new request. Requesters must drop read/write on the edge after resp.
- read and write both high at acceptance: the request is a write and the read is ignored. There is exactly one resp.
- write with wmask=0: completes normally and modifies nothing.
- Inputs are latched at acceptance. Changes while BUSY are ignored.
- Simultaneous completions on the same edge:
  - Read vs write to the same word: the read returns the pre-write data (read-before-write).
  - Write vs write to the same word: merge per byte; for each byte, the highest-indexed port with its mask bit set wins.
- rdata holds its last value outside resp, except after reset, when it is 0.
- Memory contents are not cleared by rst. They are zero at simulation time 0.

## Timing
- Reset values: resp=0, rdata=0 for every port; every FSM in IDLE; counters 0.
- Reset mid-operation: in-flight requests are discarded, uncommitted writes are never applied, and no resp is issued.
- Request accepted at edge k gives resp high during cycle k+LATENCY. With LATENCY=1, resp is high in the cycle right after acceptance.
- Maximum throughput per port is one request per LATENCY+1 cycles.
- A write is visible to any read whose capture edge is strictly later than the write's commit edge.
- No combinational path from any input to any output.

## Structure
- Package pmem_mp_pkg holds:
  - the port state enum typedef (IDLE, BUSY, DONE);
  - a `clog2`-style helper function, or localparam derivations for the mask width and byte-offset width.
- Sub-module pmem_mp_port holds one port's FSM, latency counter and request latch. It exports a commit strobe plus latched op, index, wdata and wmask. It is instantiated NUM_PORTS times in a generate loop.
- The top level owns the storage array, the read capture and the priority byte-merge of commits.

## Test plan
- Reset and basic read, LATENCY=3: assert rst for 2 cycles, then read port 0 at address 0x0000. Required: resp low during reset; resp exactly 3 cycles after acceptance; rdata=0x0000.
- Masked write and readback: port 0 writes 0xBEEF to 0x0010 with wmask=2'b11, then writes 0x12xx with wmask=2'b10. A port 1 read of 0x0011 (odd byte offset ignored) must return 0x12EF.
- Same-edge conflict: both ports write word 0x0020 on the same cycle, port 0 with 0xAAAA, mask 11 and port 1 with 0x5555, mask 01. Required result: 0xAA55. A read completing on that same edge returns the old value.
- Read-and-write both high: port 0 has read=1, write=1, wdata=0x1234 to 0x0030. Required: one resp pulse and memory holds 0x1234.
- Reset mid-request: a write of 0xFFFF to 0x0040 is accepted, then rst is asserted one cycle later. Required: no resp, and a later read returns 0x0000.
- Parameter sweep: LATENCY in {1, 5}, NUM_PORTS=4, DATA_WIDTH=32, with addresses above DEPTH_WORDS. Required:
  - resp at exactly k+LATENCY;
  - addresses wrap;
  - back-to-back requests are spaced LATENCY+1 cycles apart.

Source files
------------

// File: rtl/pmem_mp_pkg.sv
// Shared types and helpers for the multi-port latency memory model.
package pmem_mp_pkg;

  // Per-port request state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } port_state_e;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pmem_mp_port.sv
// One request port: accepts a read or write, holds it for LATENCY cycles,
// strobes commit on the completion edge and pulses resp in the cycle after.
module pmem_mp_port
  import pmem_mp_pkg::*;
#(
  parameter int LATENCY    = 3,
  parameter int DATA_WIDTH = 16,
  parameter int MASK_W     = 2,
  parameter int IDX_W      = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [MASK_W-1:0]     i_wmask,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_commit,
  output logic                  o_is_write,
  output logic [IDX_W-1:0]      o_idx,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [MASK_W-1:0]     o_wmask,
  output logic                  o_resp
);

  localparam int CNT_W = (clog2(LATENCY) < 1) ? 1 : clog2(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  port_state_e           r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_resp;
  logic                  r_is_write;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [MASK_W-1:0]     r_wmask;
  logic                  w_req;

  assign w_req = i_read | i_write;

  // Request FSM: latch on acceptance, count down, pulse resp once.
  // A request still high in the resp cycle is taken as the next request,
  // which gives one request per LATENCY+1 cycles at full rate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_resp     <= 1'b0;
      r_is_write <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_resp <= 1'b0;
          if (w_req) begin
            r_is_write <= i_write;
            r_idx      <= i_idx;
            r_wdata    <= i_wdata;
            r_wmask    <= i_wmask;
            r_cnt      <= CNT_LOAD;
            r_state    <= BUSY;
          end else begin
            r_state <= IDLE;
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            r_state <= DONE;
            r_resp  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_resp  <= 1'b0;
        end
      endcase
    end
  end

  assign o_commit   = (r_state == BUSY) && (r_cnt == '0);
  assign o_is_write = r_is_write;
  assign o_idx      = r_idx;
  assign o_wdata    = r_wdata;
  assign o_wmask    = r_wmask;
  assign o_resp     = r_resp;

endmodule

// File: rtl/pmem_mp_latency.sv
// Multi-port physical memory with byte-masked writes and fixed latency.
// Storage, read capture and per-byte priority merge of same-edge commits.
module pmem_mp_latency
  import pmem_mp_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH_WORDS = 4096,
  parameter int NUM_PORTS   = 2,
  parameter int LATENCY     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    read    [NUM_PORTS],
  input  logic                    write   [NUM_PORTS],
  input  logic [DATA_WIDTH/8-1:0] wmask   [NUM_PORTS],
  input  logic [ADDR_WIDTH-1:0]   address [NUM_PORTS],
  input  logic [DATA_WIDTH-1:0]   wdata   [NUM_PORTS],
  output logic                    resp    [NUM_PORTS],
  output logic [DATA_WIDTH-1:0]   rdata   [NUM_PORTS]
);

  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int OFF_W  = clog2(MASK_W);
  localparam int IDX_W  = clog2(DEPTH_WORDS);

  logic [DATA_WIDTH-1:0] r_mem     [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] r_rdata   [NUM_PORTS];
  logic [IDX_W-1:0]      w_req_idx [NUM_PORTS];
  logic                  w_commit  [NUM_PORTS];
  logic                  w_fire    [NUM_PORTS];
  logic                  w_is_write[NUM_PORTS];
  logic [IDX_W-1:0]      w_idx     [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_wdata   [NUM_PORTS];
  logic [MASK_W-1:0]     w_wmask   [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    // Byte offset dropped, upper bits wrap modulo the depth.
    assign w_req_idx[g] = address[g][OFF_W +: IDX_W];
    // A commit coinciding with reset is discarded.
    assign w_fire[g]    = w_commit[g] & ~rst;
    assign rdata[g]     = r_rdata[g];

    pmem_mp_port #(
      .LATENCY   (LATENCY),
      .DATA_WIDTH(DATA_WIDTH),
      .MASK_W    (MASK_W),
      .IDX_W     (IDX_W)
    ) u_port (
      .clk       (clk),
      .rst       (rst),
      .i_read    (read[g]),
      .i_write   (write[g]),
      .i_wmask   (wmask[g]),
      .i_idx     (w_req_idx[g]),
      .i_wdata   (wdata[g]),
      .o_commit  (w_commit[g]),
      .o_is_write(w_is_write[g]),
      .o_idx     (w_idx[g]),
      .o_wdata   (w_wdata[g]),
      .o_wmask   (w_wmask[g]),
      .o_resp    (resp[g])
    );
  end

  // Apply committing writes in ascending port order so the highest port wins each byte.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_fire[p] && w_is_write[p]) begin
        for (int b = 0; b < MASK_W; b++) begin
          if (w_wmask[p][b]) begin
            r_mem[w_idx[p]][b*8 +: 8] <= w_wdata[p][b*8 +: 8];
          end
        end
      end
    end
  end

  // Capture read data on the completion edge; sees pre-write contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_rdata[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_fire[p] && !w_is_write[p]) begin
          r_rdata[p] <= r_mem[w_idx[p]];
        end
      end
    end
  end

endmodule

// File: tb/tb_pmem_mp_latency.sv
// Bench for pmem_mp_latency: default instance (16b, 2 ports, latency 3)
// plus two 32b/4-port instances with latency 1 and 5 driven in lockstep.
module tb_pmem_mp_latency;

  localparam int L_A = 1;
  localparam int L_B = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        rd0 [2], wr0 [2], resp0 [2];
  logic [1:0]  m0  [2];
  logic [15:0] ad0 [2], wd0 [2], rdata0 [2];

  logic        rd1 [4], wr1 [4], resp1 [4];
  logic        rd5 [4], wr5 [4], resp5 [4];
  logic [3:0]  m1  [4], m5  [4];
  logic [15:0] ad1 [4], ad5 [4];
  logic [31:0] wd1 [4], wd5 [4], rdata1 [4], rdata5 [4];

  pmem_mp_latency u_dut0 (
    .clk(clk), .rst(rst), .read(rd0), .write(wr0), .wmask(m0),
    .address(ad0), .wdata(wd0), .resp(resp0), .rdata(rdata0));

  pmem_mp_latency #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH_WORDS(256),
                    .NUM_PORTS(4), .LATENCY(L_A)) u_dut1 (
    .clk(clk), .rst(rst), .read(rd1), .write(wr1), .wmask(m1),
    .address(ad1), .wdata(wd1), .resp(resp1), .rdata(rdata1));

  pmem_mp_latency #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH_WORDS(256),
                    .NUM_PORTS(4), .LATENCY(L_B)) u_dut5 (
    .clk(clk), .rst(rst), .read(rd5), .write(wr5), .wmask(m5),
    .address(ad5), .wdata(wd5), .resp(resp5), .rdata(rdata5));

  typedef struct {
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [3:0]  m;
  } req_t;

  req_t        rq [4];
  bit   [31:0] mdl [2][4096];   // [0]: default instance, [1]: both sweep instances
  logic [31:0] cap [3][4];
  int          lat_of [3];
  int          checks = 0;
  int          errors = 0;
  int          t1 [$];
  int          t5 [$];
  int          op;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic setrq(input int p, input bit r, input bit w, input logic [15:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    rq[p].rd = r; rq[p].wr = w; rq[p].addr = a; rq[p].wd = d; rq[p].m = m;
  endtask

  task automatic clr_rq();
    for (int p = 0; p < 4; p++) setrq(p, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
  endtask

  function automatic int widx(input int which, input logic [15:0] a);
    return (which == 0) ? int'(a[12:1]) : int'(a[9:2]);
  endfunction

  function automatic logic get_resp(input int i, input int p);
    if (i == 0) return resp0[p % 2];
    else if (i == 1) return resp1[p];
    else return resp5[p];
  endfunction

  function automatic logic [31:0] get_rdata(input int i, input int p);
    if (i == 0) return {16'h0, rdata0[p % 2]};
    else if (i == 1) return rdata1[p];
    else return rdata5[p];
  endfunction

  task automatic drop(input int i, input int p);
    if (i == 0) begin rd0[p % 2] = 1'b0; wr0[p % 2] = 1'b0; end
    else if (i == 1) begin rd1[p] = 1'b0; wr1[p] = 1'b0; end
    else begin rd5[p] = 1'b0; wr5[p] = 1'b0; end
  endtask

  // Issue rq[] on all ports at once; model: reads see old contents, then
  // writes land in ascending port order byte by byte.
  task automatic exec(input int which);
    int np, ilo, ihi, nb, w;
    logic [31:0] expd [4];
    int first [3][4];
    int pulses [3][4];
    np  = (which != 0) ? 4 : 2;
    nb  = (which != 0) ? 4 : 2;
    ilo = (which != 0) ? 1 : 0;
    ihi = (which != 0) ? 2 : 0;
    for (int p = 0; p < np; p++) expd[p] = mdl[which][widx(which, rq[p].addr)];
    for (int p = 0; p < np; p++) begin
      w = widx(which, rq[p].addr);
      if (rq[p].wr)
        for (int b = 0; b < nb; b++)
          if (rq[p].m[b]) mdl[which][w][b*8 +: 8] = rq[p].wd[b*8 +: 8];
    end
    for (int p = 0; p < np; p++) begin
      if (which == 0) begin
        rd0[p] = rq[p].rd; wr0[p] = rq[p].wr; ad0[p] = rq[p].addr;
        wd0[p] = rq[p].wd[15:0]; m0[p] = rq[p].m[1:0];
      end else begin
        rd1[p] = rq[p].rd; wr1[p] = rq[p].wr; ad1[p] = rq[p].addr; wd1[p] = rq[p].wd; m1[p] = rq[p].m;
        rd5[p] = rq[p].rd; wr5[p] = rq[p].wr; ad5[p] = rq[p].addr; wd5[p] = rq[p].wd; m5[p] = rq[p].m;
      end
    end
    for (int i = ilo; i <= ihi; i++)
      for (int p = 0; p < np; p++) begin first[i][p] = -1; pulses[i][p] = 0; end
    tick();  // acceptance edge
    for (int c = 1; c <= 8; c++) begin
      tick();
      for (int i = ilo; i <= ihi; i++)
        for (int p = 0; p < np; p++)
          if (get_resp(i, p)) begin
            pulses[i][p]++;
            if (first[i][p] < 0) begin
              first[i][p] = c;
              cap[i][p] = get_rdata(i, p);
              drop(i, p);
            end
          end
    end
    for (int i = ilo; i <= ihi; i++)
      for (int p = 0; p < np; p++) begin
        if (rq[p].rd || rq[p].wr) begin
          chk("latency", first[i][p], lat_of[i]);
          chk("one_pulse", pulses[i][p], 32'd1);
          if (rq[p].rd && !rq[p].wr) chk("rdata", cap[i][p], expd[p]);
        end else begin
          chk("no_resp_idle", pulses[i][p], 32'd0);
        end
      end
  endtask

  initial begin
    lat_of[0] = 3; lat_of[1] = L_A; lat_of[2] = L_B;
    for (int p = 0; p < 2; p++) begin
      rd0[p] = 1'b0; wr0[p] = 1'b0; m0[p] = 2'b00; ad0[p] = 16'h0; wd0[p] = 16'h0;
    end
    for (int p = 0; p < 4; p++) begin
      rd1[p] = 1'b0; wr1[p] = 1'b0; m1[p] = 4'h0; ad1[p] = 16'h0; wd1[p] = 32'h0;
      rd5[p] = 1'b0; wr5[p] = 1'b0; m5[p] = 4'h0; ad5[p] = 16'h0; wd5[p] = 32'h0;
    end
    clr_rq();

    // Reset for two cycles: outputs quiet and zero.
    rst = 1'b1;
    tick();
    tick();
    for (int p = 0; p < 2; p++) begin
      chk("reset_resp", {31'h0, resp0[p]}, 32'd0);
      chk("reset_rdata", {16'h0, rdata0[p]}, 32'd0);
    end
    rst = 1'b0;

    // Basic read of address 0.
    clr_rq(); setrq(0, 1'b1, 1'b0, 16'h0000, 32'h0, 4'h0); exec(0);
    chk("basic_read", cap[0][0], 32'h0000);

    // Masked write, then odd-offset readback on port 1.
    clr_rq(); setrq(0, 1'b0, 1'b1, 16'h0010, 32'hBEEF, 4'b0011); exec(0);
    clr_rq(); setrq(0, 1'b0, 1'b1, 16'h0010, 32'h1234, 4'b0010); exec(0);
    clr_rq(); setrq(1, 1'b1, 1'b0, 16'h0011, 32'h0, 4'h0); exec(0);
    chk("masked_readback", cap[0][1], 32'h12EF);

    // Same-edge write/write merge.
    clr_rq();
    setrq(0, 1'b0, 1'b1, 16'h0020, 32'hAAAA, 4'b0011);
    setrq(1, 1'b0, 1'b1, 16'h0020, 32'h5555, 4'b0001);
    exec(0);
    clr_rq(); setrq(0, 1'b1, 1'b0, 16'h0020, 32'h0, 4'h0); exec(0);
    chk("ww_merge", cap[0][0], 32'hAA55);

    // Same-edge read/write: read sees old data, later read sees new.
    clr_rq();
    setrq(0, 1'b0, 1'b1, 16'h0020, 32'h1111, 4'b0011);
    setrq(1, 1'b1, 1'b0, 16'h0020, 32'h0, 4'h0);
    exec(0);
    chk("rw_old_data", cap[0][1], 32'hAA55);
    clr_rq(); setrq(1, 1'b1, 1'b0, 16'h0020, 32'h0, 4'h0); exec(0);
    chk("rw_new_data", cap[0][1], 32'h1111);

    // Read and write both high: a single write.
    clr_rq(); setrq(0, 1'b1, 1'b1, 16'h0030, 32'h1234, 4'b0011); exec(0);
    // Write with zero mask changes nothing.
    clr_rq(); setrq(1, 1'b0, 1'b1, 16'h0030, 32'hFFFF, 4'b0000); exec(0);
    clr_rq(); setrq(0, 1'b1, 1'b0, 16'h0030, 32'h0, 4'h0); exec(0);
    chk("rdwr_and_mask0", cap[0][0], 32'h1234);

    // Reset one cycle after a write is accepted.
    wr0[0] = 1'b1; ad0[0] = 16'h0040; wd0[0] = 16'hFFFF; m0[0] = 2'b11;
    tick();
    rst = 1'b1;
    tick();
    wr0[0] = 1'b0;
    chk("rst_mid_resp_a", {31'h0, resp0[0]}, 32'd0);
    tick();
    chk("rst_mid_resp_b", {31'h0, resp0[0]}, 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rst_mid_no_resp", {31'h0, resp0[0]}, 32'd0);
    end
    chk("rst_rdata_p0", {16'h0, rdata0[0]}, 32'd0);
    clr_rq();
    setrq(0, 1'b1, 1'b0, 16'h0040, 32'h0, 4'h0);
    setrq(1, 1'b1, 1'b0, 16'h0030, 32'h0, 4'h0);
    exec(0);
    chk("rst_write_dropped", cap[0][0], 32'h0000);
    chk("mem_kept_over_rst", cap[0][1], 32'h1234);

    // Random traffic on a few colliding words.
    for (int it = 0; it < 30; it++) begin
      clr_rq();
      for (int p = 0; p < 2; p++) begin
        op = $urandom_range(0, 4);
        setrq(p, (op == 1) || (op == 2) || (op == 4), (op >= 3),
              16'h0100 | 16'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 3)));
      end
      exec(0);
    end

    // Sweep instances: write above depth, read through the wrapped alias.
    clr_rq(); setrq(2, 1'b0, 1'b1, 16'h0404, 32'hCAFEBABE, 4'hF); exec(1);
    clr_rq(); setrq(0, 1'b1, 1'b0, 16'h0004, 32'h0, 4'h0); exec(1);
    chk("wrap_l1", cap[1][0], 32'hCAFEBABE);
    chk("wrap_l5", cap[2][0], 32'hCAFEBABE);

    // Four-port same-edge merge.
    clr_rq();
    setrq(0, 1'b0, 1'b1, 16'h0020, 32'h11111111, 4'b1111);
    setrq(1, 1'b0, 1'b1, 16'h0020, 32'h22222222, 4'b0011);
    setrq(2, 1'b0, 1'b1, 16'h0020, 32'h33333333, 4'b0100);
    setrq(3, 1'b0, 1'b1, 16'h0020, 32'h44444444, 4'b0000);
    exec(1);
    clr_rq(); setrq(1, 1'b1, 1'b0, 16'h0420, 32'h0, 4'h0); exec(1);
    chk("merge4_l1", cap[1][1], 32'h11332222);
    chk("merge4_l5", cap[2][1], 32'h11332222);

    // Held read on port 3: responses every LATENCY+1 cycles.
    rd1[3] = 1'b1; ad1[3] = 16'h0004;
    rd5[3] = 1'b1; ad5[3] = 16'h0004;
    tick();
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (resp1[3]) t1.push_back(c);
      if (resp5[3]) t5.push_back(c);
    end
    rd1[3] = 1'b0; rd5[3] = 1'b0;
    repeat (12) tick();
    chk("tput_l1_count", t1.size(), 32'd10);
    chk("tput_l5_count", t5.size(), 32'd3);
    if (t1.size() >= 3) begin
      chk("tput_l1_first", t1[0], L_A);
      chk("tput_l1_gap_a", t1[1] - t1[0], L_A + 1);
      chk("tput_l1_gap_b", t1[2] - t1[1], L_A + 1);
    end
    if (t5.size() >= 3) begin
      chk("tput_l5_first", t5[0], L_B);
      chk("tput_l5_gap_a", t5[1] - t5[0], L_B + 1);
      chk("tput_l5_gap_b", t5[2] - t5[1], L_B + 1);
    end

    // Random four-port traffic with wrapping upper address bits.
    for (int it = 0; it < 12; it++) begin
      clr_rq();
      for (int p = 0; p < 4; p++) begin
        op = $urandom_range(0, 4);
        setrq(p, (op == 1) || (op == 2) || (op == 4), (op >= 3),
              16'(($urandom_range(0, 63) << 10) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3)),
              $urandom, 4'($urandom_range(0, 15)));
      end
      exec(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
